// File: rtl/p2s_pkg.sv
// +----------------------------------------------------------------------+
// | p2s_pkg : shared constants and state encoding for the p2s arbiter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package p2s_pkg;

  localparam int LANES = 4;
  localparam int W     = 8;
  localparam int NIB   = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HI   = 2'd1;
  localparam logic [1:0] ST_LO   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_HI   = ST_HI,
    S_LO   = ST_LO,
    S_BAD  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/p2s_rr_pick.sv
// +----------------------------------------------------------------------+
// | p2s_rr_pick : rotate-priority encoder, first requester from ptr      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module p2s_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] win
);

  logic [1:0] w_idx;

  // Scan from the farthest offset down so the lane nearest ptr wins last.
  always_comb begin
    any   = 1'b0;
    win   = 2'd0;
    w_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      w_idx = ptr + 2'(i);
      if (req[w_idx]) begin
        any = 1'b1;
        win = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/p2s_lane_arbiter.sv
// +----------------------------------------------------------------------+
// | p2s_lane_arbiter : round-robin 4-lane byte arbiter, nibble sequencer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module p2s_lane_arbiter #(
  parameter int LANES = 4,
  parameter int W     = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             ENB,
  input  logic [LANES-1:0] req,
  input  logic [W-1:0]     D0,
  input  logic [W-1:0]     D1,
  input  logic [W-1:0]     D2,
  input  logic [W-1:0]     D3,
  output logic [LANES-1:0] gnt,
  output logic [3:0]       data_out,
  output logic             valid_out,
  output logic [1:0]       lane_out,
  output logic             first_out,
  output logic             busy,
  output logic [7:0]       sent_cnt
);
  import p2s_pkg::*;

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_byte, w_byte_nxt;
  logic [1:0]       r_id, w_id_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [7:0]       r_sent_cnt, w_cnt_nxt;

  logic [LANES-1:0] r_gnt, w_gnt_nxt;
  logic [3:0]       r_data, w_data_nxt;
  logic             r_valid, w_valid_nxt;
  logic [1:0]       r_lane, w_lane_nxt;
  logic             r_first, w_first_nxt;
  logic             r_busy, w_busy_nxt;

  logic             w_any;
  logic [1:0]       w_win;
  logic [W-1:0]     w_dsel;
  logic             w_load;

  p2s_rr_pick u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .win (w_win)
  );

  always_comb begin
    case (w_win)
      2'd0:    w_dsel = D0;
      2'd1:    w_dsel = D1;
      2'd2:    w_dsel = D2;
      default: w_dsel = D3;
    endcase
  end

  // Outputs are computed one cycle ahead and registered alongside the state.
  always_comb begin
    w_state_nxt = S_IDLE;
    w_byte_nxt  = r_byte;
    w_id_nxt    = r_id;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_sent_cnt;
    w_gnt_nxt   = '0;
    w_data_nxt  = 4'd0;
    w_valid_nxt = 1'b0;
    w_lane_nxt  = 2'd0;
    w_first_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_load      = 1'b0;

    case (r_state)
      S_IDLE: w_load = ENB & w_any;
      S_HI: begin
        w_state_nxt = S_LO;
        w_data_nxt  = r_byte[NIB-1:0];
        w_valid_nxt = 1'b1;
        w_lane_nxt  = r_id;
        w_busy_nxt  = 1'b1;
      end
      S_LO: begin
        w_cnt_nxt = r_sent_cnt + 8'd1;
        w_load    = ENB & w_any;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_load) begin
      w_state_nxt      = S_HI;
      w_byte_nxt       = w_dsel;
      w_id_nxt         = w_win;
      w_ptr_nxt        = w_win + 2'd1;
      w_data_nxt       = w_dsel[W-1 -: NIB];
      w_valid_nxt      = 1'b1;
      w_lane_nxt       = w_win;
      w_first_nxt      = 1'b1;
      w_busy_nxt       = 1'b1;
      w_gnt_nxt[w_win] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_byte     <= '0;
      r_id       <= 2'd0;
      r_ptr      <= 2'd0;
      r_sent_cnt <= 8'd0;
      r_gnt      <= '0;
      r_data     <= 4'd0;
      r_valid    <= 1'b0;
      r_lane     <= 2'd0;
      r_first    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte     <= w_byte_nxt;
      r_id       <= w_id_nxt;
      r_ptr      <= w_ptr_nxt;
      r_sent_cnt <= w_cnt_nxt;
      r_gnt      <= w_gnt_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_lane     <= w_lane_nxt;
      r_first    <= w_first_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign lane_out  = r_lane;
  assign first_out = r_first;
  assign busy      = r_busy;
  assign sent_cnt  = r_sent_cnt;

endmodule

`default_nettype wire

// File: tb/tb_p2s_lane_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_p2s_lane_arbiter : directed self-checking bench for the arbiter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_p2s_lane_arbiter;

  logic       CLK = 1'b0;
  logic       reset;
  logic       ENB;
  logic [3:0] req;
  logic [7:0] D0, D1, D2, D3;
  logic [3:0] gnt;
  logic [3:0] data_out;
  logic       valid_out;
  logic [1:0] lane_out;
  logic       first_out;
  logic       busy;
  logic [7:0] sent_cnt;

  int ntot  = 0;
  int npass = 0;
  int nfail = 0;

  p2s_lane_arbiter #(.LANES(4), .W(8)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .ENB       (ENB),
    .req       (req),
    .D0        (D0),
    .D1        (D1),
    .D2        (D2),
    .D3        (D3),
    .gnt       (gnt),
    .data_out  (data_out),
    .valid_out (valid_out),
    .lane_out  (lane_out),
    .first_out (first_out),
    .busy      (busy),
    .sent_cnt  (sent_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] d,
                         input logic [1:0] l, input logic f, input logic [3:0] g,
                         input logic b);
    chk({tag, ".valid"}, 32'(valid_out), 32'(v));
    chk({tag, ".data"},  32'(data_out),  32'(d));
    chk({tag, ".lane"},  32'(lane_out),  32'(l));
    chk({tag, ".first"}, 32'(first_out), 32'(f));
    chk({tag, ".gnt"},   32'(gnt),       32'(g));
    chk({tag, ".busy"},  32'(busy),      32'(b));
  endtask

  initial begin
    reset = 1'b1; ENB = 1'b0; req = 4'b0000;
    D0 = 8'h00; D1 = 8'h00; D2 = 8'h00; D3 = 8'h00;

    // Reset state
    tick(); tick();
    chk_out("reset", 1'b0, 4'h0, 2'd0, 1'b0, 4'b0000, 1'b0);
    chk("reset.cnt", 32'(sent_cnt), 32'd0);

    // Single lane 0, byte A5
    reset = 1'b0; ENB = 1'b1; req = 4'b0001; D0 = 8'hA5;
    tick();
    chk_out("single.hi", 1'b1, 4'hA, 2'd0, 1'b1, 4'b0001, 1'b1);
    req = 4'b0000;
    tick();
    chk_out("single.lo", 1'b1, 4'h5, 2'd0, 1'b0, 4'b0000, 1'b1);
    chk("single.cnt_lo", 32'(sent_cnt), 32'd0);
    tick();
    chk_out("single.idle", 1'b0, 4'h0, 2'd0, 1'b0, 4'b0000, 1'b0);
    chk("single.cnt", 32'(sent_cnt), 32'd1);

    // Round robin, all lanes requesting from ptr=0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    D0 = 8'h01; D1 = 8'h23; D2 = 8'h45; D3 = 8'h67; req = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out($sformatf("rr%0d", i), 1'b1, 4'(i % 8), 2'((i / 2) % 4),
              (i % 2) == 0, ((i % 2) == 0) ? 4'(1 << ((i / 2) % 4)) : 4'b0000, 1'b1);
    end
    chk("rr.cnt", 32'(sent_cnt), 32'd4);
    req = 4'b0000;
    tick();
    chk("rr.cnt_end", 32'(sent_cnt), 32'd5);

    // Pointer fairness: grant lane 2, then req=0101 goes to lane 0, then lane 2
    D2 = 8'hC3; req = 4'b0100;
    tick();
    chk_out("fair.l2", 1'b1, 4'hC, 2'd2, 1'b1, 4'b0100, 1'b1);
    req = 4'b0101;
    tick();
    chk_out("fair.l2lo", 1'b1, 4'h3, 2'd2, 1'b0, 4'b0000, 1'b1);
    tick();
    chk_out("fair.l0", 1'b1, 4'h0, 2'd0, 1'b1, 4'b0001, 1'b1);
    tick();
    tick();
    chk_out("fair.l2b", 1'b1, 4'hC, 2'd2, 1'b1, 4'b0100, 1'b1);
    req = 4'b0000;
    tick(); tick();
    chk("fair.cnt", 32'(sent_cnt), 32'd8);

    // ENB low during HI of lane 1
    D1 = 8'h89; req = 4'b0010;
    tick();
    chk_out("enb.hi", 1'b1, 4'h8, 2'd1, 1'b1, 4'b0010, 1'b1);
    ENB = 1'b0;
    tick();
    chk_out("enb.lo", 1'b1, 4'h9, 2'd1, 1'b0, 4'b0000, 1'b1);
    tick();
    chk_out("enb.idle", 1'b0, 4'h0, 2'd0, 1'b0, 4'b0000, 1'b0);
    tick();
    chk("enb.idle2.gnt", 32'(gnt), 32'd0);
    chk("enb.cnt", 32'(sent_cnt), 32'd9);
    ENB = 1'b1; req = 4'hF;
    tick();
    chk_out("enb.resume", 1'b1, 4'hC, 2'd2, 1'b1, 4'b0100, 1'b1);

    // Reset during HI discards the byte
    reset = 1'b1;
    tick();
    chk_out("rstmid", 1'b0, 4'h0, 2'd0, 1'b0, 4'b0000, 1'b0);
    chk("rstmid.cnt", 32'(sent_cnt), 32'd0);
    reset = 1'b0; req = 4'b0000;
    tick();
    chk_out("rstmid.nolo", 1'b0, 4'h0, 2'd0, 1'b0, 4'b0000, 1'b0);

    // Counter wrap: 256+ back-to-back bytes, ptr restarted at 0
    req = 4'hF;
    for (int t = 1; t <= 513; t++) begin
      tick();
      chk($sformatf("wrap.busy%0d", t), 32'(busy), 32'd1);
      chk($sformatf("wrap.valid%0d", t), 32'(valid_out), 32'd1);
      if (t == 1)   chk("wrap.first_lane", 32'(lane_out), 32'd0);
      if (t == 511) chk("wrap.cnt255", 32'(sent_cnt), 32'd255);
      if (t == 513) chk("wrap.cnt0", 32'(sent_cnt), 32'd0);
    end
    req = 4'b0000;
    tick(); tick();
    chk("wrap.idle", 32'(valid_out), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/p2s_lane_arbiter.md
# p2s_lane_arbiter

Round-robin arbiter and sequencer that shares one nibble-wide parallel-to-serial output channel between four 8-bit byte requesters (lanes D0..D3). It selects a lane, captures its byte, acknowledges the requester and emits the byte as two 4-bit nibbles tagged with the lane number. It sits between the lane sources and the p2s serial output stage, in place of a free-running `sel` counter.

## Interface
Parameters:
- `LANES`, 4: number of requesters (fixed at 4; lane id is 2 bits).
- `W`, 8: byte width per lane.

Ports:
- `CLK`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `ENB`  in  1: enable; when low, no new byte is captured.
- `req`  in  4: `req[k]` high means lane k has a valid byte on `Dk`.
- `D0`, `D1`, `D2`, `D3`  in  8 each: lane bytes; held stable while `req[k]` is high and until `gnt[k]` is seen.
- `gnt`  out  4: one-hot, one-cycle acknowledge for the captured lane.
- `data_out`  out  4: nibble output.
- `valid_out`  out  1: `data_out` carries a nibble.
- `lane_out`  out  2: lane id of the nibble currently on `data_out`.
- `first_out`  out  1: high on the high (first) nibble of a byte.
- `busy`  out  1: a byte is in flight.
- `sent_cnt`  out  8: bytes completed, wraps modulo 256.

## Operation
- FSM states: `IDLE`, `HI`, `LO`.
- Capture condition, evaluated at an edge in `IDLE` or `LO`: `reset` low, `ENB` high, `req != 0`.
  - Winner: the first requesting lane scanning `ptr, ptr+1, ... ptr+3` (mod 4).
  - At that edge: latch byte `Dwinner` and id `winner`, set `ptr <= winner+1` (mod 4), go to `HI`.
- `HI`:
  - `data_out = byte[7:4]`, `valid_out = 1`, `first_out = 1`, `lane_out = id`, `gnt[id] = 1`, `busy = 1`.
  - Next state is always `LO`.
- `LO`:
  - `data_out = byte[3:0]`, `valid_out = 1`, `first_out = 0`, `gnt = 0`, `busy = 1`.
  - At the edge ending `LO`: `sent_cnt` increments (255 wraps to 0).
  - Next state: capture condition true → back-to-back capture into `HI`; otherwise `IDLE`.
- `IDLE`: `valid_out = 0`, `busy = 0`, `gnt = 0`, `data_out = 0`, `lane_out = 0`, `first_out = 0`.
- All outputs are registered. No combinational path from inputs to outputs.
- `ENB` deasserted in `HI` or `LO`: the current byte completes (both nibbles), then the FSM goes to `IDLE`. `ENB` has no effect on a byte already captured.
- `req` deasserted by a lane before capture: not granted, no side effect.
- Requester protocol:
  - On seeing `gnt[k]`, the lane presents its next byte or drops `req[k]` at the following edge.
  - The arbiter samples `req` no earlier than the end of `LO`, so a lane is never granted twice for one byte.
- Reset (any state, including mid-byte):
  - At the next edge: state `IDLE`, `ptr = 0`, `sent_cnt = 0`, all outputs 0.
  - A partially sent byte is discarded.

## Timing
- Capture at edge E: `HI` outputs and `gnt` are valid in cycle E+1, `LO` nibble in cycle E+2.
- Throughput: 1 byte per 2 cycles with continuous requests; `valid_out` stays high continuously.
- Idle-to-first-nibble latency: 1 cycle after the edge at which `req`/`ENB` is sampled high.
- `gnt[k]` is high for exactly 1 cycle per byte, coincident with `first_out`.
- `sent_cnt` updates on the edge ending `LO`; the new value is visible in the following cycle.

## Structure
- Shared package `p2s_pkg`:
  - `LANES`, `W`, `NIB = 4`.
  - State encoding constants `ST_IDLE = 2'd0`, `ST_HI = 2'd1`, `ST_LO = 2'd2`.
  - `2'd3` is unused and recovers to `IDLE` on the next edge.
- Sub-module `p2s_rr_pick`: combinational rotate-priority encoder.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: `any`, `win[1:0]`.
  - Instantiated once.
- Remaining logic (FSM, byte/id latch, `ptr`, counter, output registers) lives in `p2s_lane_arbiter`.

## Test plan
- Reset, then single lane: `reset` held 2 cycles, `ENB=1`, `req=4'b0001`, `D0=8'hA5` → `gnt=4'b0001` and `data_out=4'hA` with `first_out=1`, then `data_out=4'h5`, `lane_out=0`, `sent_cnt=1`.
- Round robin with all lanes requesting: `req=4'hF`, `D0..D3 = 8'h01, 8'h23, 8'h45, 8'h67` → lanes granted in order 0,1,2,3,0; `data_out` sequence `0,1,2,3,4,5,6,7,0,1`; `valid_out` never drops.
- Pointer fairness: after a grant to lane 2, `req=4'b0101` → lane 0 is granted next; the following grant with the same `req` goes to lane 2.
- `ENB` low mid-byte: deassert `ENB` in the `HI` cycle of lane 1 byte `8'h89` → `data_out=4'h9` still follows, then `IDLE`; no `gnt` while `ENB=0`; resumes at the next `ptr` lane once `ENB=1`.
- Reset mid-byte: assert `reset` in `HI` → next cycle all outputs 0, `sent_cnt=0`, and the `LO` nibble is never emitted.
- Counter wrap: 256 back-to-back bytes → `sent_cnt` returns to 0; `busy` stays 1 throughout.
